multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Opcode-driven control FSM for the multi-cycle RV32I datapath. It is the successor to the single-cycle main decoder and spreads each instruction over fetch/decode/execute/memory/writeback states. It also supports a variable-latency memory handshake, illegal-opcode reporting and a retired-instruction counter. It sits between the instruction register and the shared datapath muxes, register file, ALU decoder and unified memory port.

Parameters:
CNT_W, 32, width of retired-instruction counter
ENABLE_JAL, 1, 1 = decode opcode 1101111; 0 = treat it as illegal
ENABLE_LUI, 1, 1 = decode opcode 0110111; 0 = treat it as illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  7  instr[6:0] from instruction register; valid from DECODE onward
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  PC load strobe (= pc_update | (branch & zero), combined externally)
pc_update  out  1  unconditional PC update
branch  out  1  conditional-branch state
ir_write  out  1  instruction register load
adr_src  out  1  0 = PC, 1 = ALU-out register as memory address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
result_src  out  2  00 = ALU-out reg, 01 = mem data reg, 10 = ALU result
alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1, 11 = zero
alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4
alu_op  out  2  00 = add, 10 = funct decode, 11 = branch compare
illegal_instr  out  1  one-cycle pulse on unsupported opcode
state_dbg  out  4  current state encoding
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- Moore FSM; outputs are a pure function of state, except the mem_ready-qualified strobes noted below. Any signal not listed for a state is 0.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BRANCH=10, LUI=11, ILLEGAL=12. Codes 13-15 go to FETCH next cycle with all outputs 0.
- Reset (async, while rst=1): state=FETCH and instr_retired=0. All strobes (ir_write, pc_update, mem_read, mem_write, reg_write, branch, illegal_instr) are forced to 0. Reset mid-instruction abandons it with no partial writes after assertion.
- FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_update equal mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALU-out). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL if ENABLE_JAL, else ILLEGAL
  - 0110111 -> LUI if ENABLE_LUI, else ILLEGAL
  - anything else -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Wait for mem_ready, then go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- LUI: alu_src_a=11, alu_src_b=01, alu_op=00, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1, then ALUWB.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=11, result_src=00, branch=1, then FETCH.
- ILLEGAL: illegal_instr=1 for exactly one cycle, then FETCH. The instruction is not retired.
- pc_write = pc_update | branch. The datapath ANDs branch with the zero flag; this block outputs only the OR of the raw signals.
- instr_retired increments by 1 on these transitions into FETCH: MEMWB->FETCH, MEMWRITE->FETCH (mem_ready=1), ALUWB->FETCH, BRANCH->FETCH. It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready tied high: R/I/LUI 4, load 5, store 4, branch 3, JAL 4, illegal 3. Each wait cycle adds 1.

Test Plan:
- Reset, mem_ready=1, opcode=0110011 -> states 0,1,6,8,0. reg_write=1 only in ALUWB, alu_op=10 in EXECR, instr_retired=1 after 4 cycles.
- Load 0000011 with mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. mem_read/adr_src=1 held in MEMREAD, result_src=01 in MEMWB, 7 cycles total.
- Store 0100011 -> MEMWRITE mem_write=1, reg_write never 1, counter +1. Branch 1100011 -> branch=1, alu_op=11, 3 cycles.
- ENABLE_JAL=0, opcode=1101111 -> ILLEGAL with illegal_instr high exactly 1 cycle, counter unchanged. Same for opcode 1111111 with defaults.
- Assert rst asynchronously mid-MEMREAD -> state_dbg=0 immediately, all strobes 0 during reset, instr_retired=0. Normal fetch resumes after release.
- CNT_W=3, run 9 R-type instructions -> instr_retired wraps 7->0, final value 1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM.
// Steps each instruction through fetch/decode/execute/memory/writeback states,
// stalls on a variable-latency memory handshake, flags unsupported opcodes and
// counts retired instructions.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   opcode                instr[6:0] from the instruction register
//   mem_ready             memory completes the current access this cycle
//   pc_write              pc_update | branch (zero flag is applied externally)
//   pc_update, branch     unconditional / conditional PC update
//   ir_write              instruction register load
//   adr_src               memory address select (0 = PC, 1 = ALU-out reg)
//   mem_read, mem_write   memory requests
//   reg_write             register file write
//   result_src            00 = ALU-out reg, 01 = mem data reg, 10 = ALU result
//   alu_src_a             00 = PC, 01 = old PC, 10 = rs1, 11 = zero
//   alu_src_b             00 = rs2, 01 = immediate, 10 = constant 4
//   alu_op                00 = add, 10 = funct decode, 11 = branch compare
//   illegal_instr         one-cycle pulse on an unsupported opcode
//   state_dbg             current state encoding
//   instr_retired         completed-instruction counter (wraps)
module multicycle_control_unit #(
  parameter int unsigned CNT_W      = 32,
  parameter bit          ENABLE_JAL = 1'b1,
  parameter bit          ENABLE_LUI = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_update,
  output logic             branch,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBranch   = 4'd10,
    StLui      = 4'd11,
    StIllegal  = 4'd12
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             ir_write_raw, pc_update_raw, branch_raw, mem_read_raw;
  logic             mem_write_raw, reg_write_raw, illegal_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    ir_write_raw  = 1'b0;
    pc_update_raw = 1'b0;
    branch_raw    = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read_raw  = 1'b1;
        alu_src_b     = 2'b10;
        result_src    = 2'b10;
        ir_write_raw  = mem_ready;
        pc_update_raw = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch target into ALU-out while decoding.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = ENABLE_JAL ? StJal : StIllegal;
          OpLui:           state_d = ENABLE_LUI ? StLui : StIllegal;
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src      = 1'b1;
        mem_read_raw = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StLui: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StJal: begin
        // Return address (old PC + 4) goes to ALU-out; PC takes the target.
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b10;
        pc_update_raw = 1'b1;
        state_d       = StAluWb;
      end
      StBranch: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b11;
        branch_raw = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StIllegal: begin
        illegal_raw = 1'b1;
        state_d     = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Strobes are gated by rst so nothing is written while reset is held.
  assign ir_write      = ir_write_raw & ~rst;
  assign pc_update     = pc_update_raw & ~rst;
  assign branch        = branch_raw & ~rst;
  assign mem_read      = mem_read_raw & ~rst;
  assign mem_write     = mem_write_raw & ~rst;
  assign reg_write     = reg_write_raw & ~rst;
  assign illegal_instr = illegal_raw & ~rst;
  assign pc_write      = pc_update | branch;
  assign state_dbg     = state_q;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default build, a build without
// JAL/LUI, and a 3-bit counter build, all driven by the same inputs.
module tb_multicycle_control_unit;

  logic       clk, rst, mem_ready;
  logic [6:0] opcode;

  logic       pc_write, pc_update, branch, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       illegal_instr;
  logic [3:0] state_dbg;
  logic [31:0] instr_retired;

  logic       n_pc_write, n_pc_update, n_branch, n_ir_write, n_adr_src, n_mem_read;
  logic       n_mem_write, n_reg_write, n_illegal;
  logic [1:0] n_result_src, n_alu_src_a, n_alu_src_b, n_alu_op;
  logic [3:0] n_state;
  logic [31:0] n_retired;

  logic       w_pc_write, w_pc_update, w_branch, w_ir_write, w_adr_src, w_mem_read;
  logic       w_mem_write, w_reg_write, w_illegal;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op;
  logic [3:0] w_state;
  logic [2:0] w_retired;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_update(pc_update), .branch(branch), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_instr(illegal_instr), .state_dbg(state_dbg), .instr_retired(instr_retired)
  );

  multicycle_control_unit #(.ENABLE_JAL(1'b0), .ENABLE_LUI(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .pc_update(n_pc_update), .branch(n_branch), .ir_write(n_ir_write),
    .adr_src(n_adr_src), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .reg_write(n_reg_write), .result_src(n_result_src), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .illegal_instr(n_illegal),
    .state_dbg(n_state), .instr_retired(n_retired)
  );

  multicycle_control_unit #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .pc_update(w_pc_update), .branch(w_branch), .ir_write(w_ir_write),
    .adr_src(w_adr_src), .mem_read(w_mem_read), .mem_write(w_mem_write),
    .reg_write(w_reg_write), .result_src(w_result_src), .alu_src_a(w_alu_src_a),
    .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .illegal_instr(w_illegal),
    .state_dbg(w_state), .instr_retired(w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 7'b0110011;
    mem_ready = 1'b1;
    step();
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_cnt", instr_retired, 0);
    rst = 1'b0;
    #1;

    // R-type: 0,1,6,8,0
    chk("r_fetch_state", 32'(state_dbg), 0);
    chk("r_fetch_mem_read", 32'(mem_read), 1);
    chk("r_fetch_ir_write", 32'(ir_write), 1);
    chk("r_fetch_pc_write", 32'(pc_write), 1);
    chk("r_fetch_srcb", 32'(alu_src_b), 2);
    chk("r_fetch_res", 32'(result_src), 2);
    step();
    chk("r_dec_state", 32'(state_dbg), 1);
    chk("r_dec_srca", 32'(alu_src_a), 1);
    chk("r_dec_srcb", 32'(alu_src_b), 1);
    chk("r_dec_ir_write", 32'(ir_write), 0);
    step();
    chk("r_exec_state", 32'(state_dbg), 6);
    chk("r_exec_aluop", 32'(alu_op), 2);
    chk("r_exec_srca", 32'(alu_src_a), 2);
    chk("r_exec_regw", 32'(reg_write), 0);
    step();
    chk("r_wb_state", 32'(state_dbg), 8);
    chk("r_wb_regw", 32'(reg_write), 1);
    chk("r_wb_res", 32'(result_src), 0);
    chk("r_wb_cnt", instr_retired, 0);
    step();
    chk("r_done_state", 32'(state_dbg), 0);
    chk("r_done_cnt", instr_retired, 1);
    chk("r_done_cnt_w", 32'(w_retired), 1);

    // Load with two stalled MEMREAD cycles: 0,1,2,3,3,3,4,0
    opcode = 7'b0000011;
    step();
    chk("ld_dec_state", 32'(state_dbg), 1);
    step();
    chk("ld_adr_state", 32'(state_dbg), 2);
    chk("ld_adr_srca", 32'(alu_src_a), 2);
    chk("ld_adr_srcb", 32'(alu_src_b), 1);
    mem_ready = 1'b0;
    step();
    chk("ld_rd1_state", 32'(state_dbg), 3);
    chk("ld_rd1_mem_read", 32'(mem_read), 1);
    chk("ld_rd1_adr_src", 32'(adr_src), 1);
    step();
    chk("ld_rd2_state", 32'(state_dbg), 3);
    step();
    chk("ld_rd3_state", 32'(state_dbg), 3);
    chk("ld_rd3_mem_read", 32'(mem_read), 1);
    mem_ready = 1'b1;
    step();
    chk("ld_wb_state", 32'(state_dbg), 4);
    chk("ld_wb_res", 32'(result_src), 1);
    chk("ld_wb_regw", 32'(reg_write), 1);
    step();
    chk("ld_done_state", 32'(state_dbg), 0);
    chk("ld_done_cnt", instr_retired, 2);

    // Store, with one FETCH stall first
    opcode    = 7'b0100011;
    mem_ready = 1'b0;
    #1;
    chk("st_stall_ir_write", 32'(ir_write), 0);
    step();
    chk("st_stall_state", 32'(state_dbg), 0);
    mem_ready = 1'b1;
    step();
    chk("st_dec_state", 32'(state_dbg), 1);
    step();
    chk("st_adr_state", 32'(state_dbg), 2);
    step();
    chk("st_wr_state", 32'(state_dbg), 5);
    chk("st_wr_mem_write", 32'(mem_write), 1);
    chk("st_wr_regw", 32'(reg_write), 0);
    chk("st_wr_adr_src", 32'(adr_src), 1);
    step();
    chk("st_done_state", 32'(state_dbg), 0);
    chk("st_done_cnt", instr_retired, 3);

    // Branch: 0,1,10,0
    opcode = 7'b1100011;
    step();
    step();
    chk("br_state", 32'(state_dbg), 10);
    chk("br_branch", 32'(branch), 1);
    chk("br_aluop", 32'(alu_op), 3);
    chk("br_pc_write", 32'(pc_write), 1);
    step();
    chk("br_done_state", 32'(state_dbg), 0);
    chk("br_done_cnt", instr_retired, 4);

    // JAL: default build goes 9,8; no-JAL build goes ILLEGAL
    opcode = 7'b1101111;
    step();
    step();
    chk("jal_state", 32'(state_dbg), 9);
    chk("jal_pc_update", 32'(pc_update), 1);
    chk("jal_srcb", 32'(alu_src_b), 2);
    chk("nj_state", 32'(n_state), 12);
    chk("nj_illegal", 32'(n_illegal), 1);
    step();
    chk("jal_wb_state", 32'(state_dbg), 8);
    chk("nj_after_state", 32'(n_state), 0);
    chk("nj_after_illegal", 32'(n_illegal), 0);
    chk("nj_cnt", n_retired, 4);
    step();
    chk("jal_done_cnt", instr_retired, 5);

    // Resynchronise all builds with a mid-cycle reset
    #2;
    rst = 1'b1;
    #1;
    chk("resync_state", 32'(state_dbg), 0);
    chk("resync_cnt", instr_retired, 0);
    step();
    rst = 1'b0;

    // Unsupported opcode: 0,1,12,0, illegal pulse for one cycle
    opcode = 7'b1111111;
    step();
    chk("ill_dec_illegal", 32'(illegal_instr), 0);
    step();
    chk("ill_state", 32'(state_dbg), 12);
    chk("ill_illegal", 32'(illegal_instr), 1);
    step();
    chk("ill_after_state", 32'(state_dbg), 0);
    chk("ill_after_illegal", 32'(illegal_instr), 0);
    chk("ill_cnt", instr_retired, 0);

    // Async reset mid-MEMREAD
    opcode = 7'b0000011;
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("ar_pre_state", 32'(state_dbg), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", 32'(state_dbg), 0);
    chk("ar_mem_read", 32'(mem_read), 0);
    chk("ar_adr_src", 32'(adr_src), 0);
    chk("ar_reg_write", 32'(reg_write), 0);
    chk("ar_pc_write", 32'(pc_write), 0);
    chk("ar_cnt", instr_retired, 0);
    mem_ready = 1'b1;
    step();
    chk("ar_hold_ir_write", 32'(ir_write), 0);
    chk("ar_hold_pc_update", 32'(pc_update), 0);
    rst = 1'b0;
    #1;
    chk("ar_rel_mem_read", 32'(mem_read), 1);

    // Nine R-type instructions; the 3-bit counter wraps 7 -> 0 -> 1
    opcode = 7'b0110011;
    step();
    chk("resume_state", 32'(state_dbg), 1);
    repeat (3) step();
    chk("wrap_cnt_1", 32'(w_retired), 1);
    for (int i = 2; i <= 9; i++) begin
      repeat (4) step();
      chk($sformatf("wrap_cnt_%0d", i), 32'(w_retired), 32'(i % 8));
    end
    chk("wrap_full_cnt", instr_retired, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
